// File: rtl/ghpcll_rnd_pkg.sv
// Shared constants, state encoding and LFSR helpers for the GHPC-LL randomness feeder.
package ghpcll_rnd_pkg;

    localparam int unsigned LFSR_W = 80;
    localparam int unsigned TAP_A  = 79;
    localparam int unsigned TAP_B  = 78;
    localparam int unsigned TAP_C  = 42;
    localparam int unsigned TAP_D  = 41;

    typedef enum logic [1:0] {StIdle, StWarmup, StRun} feeder_state_e;

    // One Fibonacci step; the feedback bit enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
        return {s[LFSR_W-2:0], fb};
    endfunction

    // Returns {next_state, word}; word bit i is the feedback of step i, bits >= n are zero.
    function automatic logic [2*LFSR_W-1:0] lfsr_word(input logic [LFSR_W-1:0] state,
                                                       input int unsigned n);
        logic [LFSR_W-1:0] s;
        logic [LFSR_W-1:0] w;
        s = state;
        w = '0;
        for (int i = 0; i < int'(LFSR_W); i++) begin
            if (i < int'(n)) begin
                s    = lfsr_step(s);
                w[i] = s[0];
            end
        end
        return {s, w};
    endfunction

endpackage

// File: rtl/ghpcll_lfsr_step.sv
// Combinational RND_W-step unrolled update of the 80-bit feeder LFSR.
module ghpcll_lfsr_step
    import ghpcll_rnd_pkg::*;
#(
    parameter int unsigned RND_W = 16
) (
    input  logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] next_state,
    output logic [RND_W-1:0]  word
);

    logic [LFSR_W-1:0] chain [0:RND_W];

    assign chain[0] = state;

    for (genvar i = 0; i < RND_W; i++) begin : g_step
        assign chain[i+1] = lfsr_step(chain[i]);
        assign word[i]    = chain[i+1][0];
    end

    assign next_state = chain[RND_W];

endmodule

// File: rtl/ghpcll_rnd_feeder.sv
// Fresh-randomness feeder for the masked AND gadgets: seeded LFSR, warm-up, valid/ready output.
// Optional saturating word counter with reseed_req output when GHPCLL_RND_RESEED_REQ_EN is defined.
module ghpcll_rnd_feeder
    import ghpcll_rnd_pkg::*;
#(
    parameter int unsigned N_AND  = 4,
    localparam int unsigned RND_W = 4 * N_AND,
    parameter int unsigned WARMUP = 8
`ifdef GHPCLL_RND_RESEED_REQ_EN
    ,
    parameter int unsigned RESEED_LIMIT = 2**20
`endif
) (
    input  logic              clk,
    input  logic              syn_rst,
    input  logic [LFSR_W-1:0] seed,
    input  logic              seed_valid,
    output logic              seed_ready,
    output logic [RND_W-1:0]  rnd_out,
    output logic              rnd_valid,
    input  logic              rnd_ready,
`ifdef GHPCLL_RND_RESEED_REQ_EN
    output logic              reseed_req,
`endif
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(WARMUP + 1);

    feeder_state_e     state;
    logic [LFSR_W-1:0] s;
    logic [CNT_W-1:0]  warm_cnt;
    logic              seed_acc;
    logic [LFSR_W-1:0] step_in;
    logic [LFSR_W-1:0] step_next;
    logic [RND_W-1:0]  step_word;

    assign seed_acc = seed_valid & seed_ready;

    // The seed-load edge already produces the first discarded word, so exactly WARMUP
    // words are thrown away and the word shown when rnd_valid rises is word number WARMUP.
    assign step_in = !seed_acc       ? s :
                     (seed == '0)    ? LFSR_W'(1) : seed;

    ghpcll_lfsr_step #(
        .RND_W(RND_W)
    ) u_step (
        .state     (step_in),
        .next_state(step_next),
        .word      (step_word)
    );

    always_ff @(posedge clk) begin
        if (syn_rst) begin
            state      <= StIdle;
            s          <= '0;
            rnd_out    <= '0;
            rnd_valid  <= 1'b0;
            busy       <= 1'b0;
            warm_cnt   <= '0;
            seed_ready <= 1'b1;
        end else if (seed_acc) begin
            state      <= StWarmup;
            s          <= step_next;
            rnd_out    <= step_word;
            rnd_valid  <= 1'b0;
            busy       <= 1'b1;
            warm_cnt   <= CNT_W'(WARMUP);
            seed_ready <= 1'b0;
        end else begin
            case (state)
                StWarmup: begin
                    s        <= step_next;
                    rnd_out  <= step_word;
                    warm_cnt <= warm_cnt - CNT_W'(1);
                    if (warm_cnt == CNT_W'(1)) begin
                        state      <= StRun;
                        rnd_valid  <= 1'b1;
                        busy       <= 1'b0;
                        seed_ready <= 1'b1;
                    end
                end
                StRun: begin
                    if (rnd_ready) begin
                        s       <= step_next;
                        rnd_out <= step_word;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GHPCLL_RND_RESEED_REQ_EN
    logic [31:0] word_cnt;

    always_ff @(posedge clk) begin
        if (syn_rst || seed_acc) begin
            word_cnt <= '0;
        end else if (rnd_valid && rnd_ready && (word_cnt != '1)) begin
            word_cnt <= word_cnt + 32'd1;
        end
    end

    assign reseed_req = (word_cnt >= RESEED_LIMIT);
`endif

endmodule

// File: tb/tb_ghpcll_rnd_feeder.sv
// Scoreboard bench for ghpcll_rnd_feeder: bit-stream recurrence model feeds an expected-word queue.
module tb_ghpcll_rnd_feeder;
    import ghpcll_rnd_pkg::*;

    localparam int unsigned N_AND  = 4;
    localparam int unsigned RND_W  = 4 * N_AND;
    localparam int unsigned WARMUP = 8;

    logic              clk        = 1'b0;
    logic              syn_rst    = 1'b1;
    logic [LFSR_W-1:0] seed       = '0;
    logic              seed_valid = 1'b0;
    logic              seed_ready;
    logic [RND_W-1:0]  rnd_out;
    logic              rnd_valid;
    logic              rnd_ready  = 1'b0;
    logic              busy;
`ifdef GHPCLL_RND_RESEED_REQ_EN
    logic              reseed_req;
`endif

    int checks = 0;
    int errors = 0;

    logic [RND_W-1:0] exp_q[$];
    bit               hist[$];

    always #5 clk = ~clk;

    ghpcll_rnd_feeder #(
        .N_AND (N_AND),
`ifdef GHPCLL_RND_RESEED_REQ_EN
        .RESEED_LIMIT(4),
`endif
        .WARMUP(WARMUP)
    ) dut (
        .clk       (clk),
        .syn_rst   (syn_rst),
        .seed      (seed),
        .seed_valid(seed_valid),
        .seed_ready(seed_ready),
        .rnd_out   (rnd_out),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
`ifdef GHPCLL_RND_RESEED_REQ_EN
        .reseed_req(reseed_req),
`endif
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Output bit stream: y[k] = y[k-80] ^ y[k-79] ^ y[k-43] ^ y[k-42], hist holds the last 80 bits.
    function automatic bit model_bit();
        bit b;
        b = hist[0] ^ hist[1] ^ hist[37] ^ hist[38];
        hist.push_back(b);
        void'(hist.pop_front());
        return b;
    endfunction

    function automatic logic [RND_W-1:0] model_word();
        logic [RND_W-1:0] w;
        for (int i = 0; i < int'(RND_W); i++) w[i] = model_bit();
        return w;
    endfunction

    task automatic model_load(input logic [LFSR_W-1:0] sv);
        hist.delete();
        for (int j = 0; j < int'(LFSR_W); j++) hist.push_back(sv[LFSR_W-1-j]);
    endtask

    task automatic model_seed(input logic [LFSR_W-1:0] sv, input int n_words);
        logic [RND_W-1:0] w;
        model_load(sv);
        for (int k = 0; k < int'(WARMUP); k++) w = model_word();
        exp_q.delete();
        for (int k = 0; k < n_words; k++) exp_q.push_back(model_word());
    endtask

    // Monitor: pops one expected word per handshake, checks hold while stalled.
    logic [RND_W-1:0] prev_out;
    logic             prev_valid = 1'b0;
    logic             prev_ready = 1'b0;

    always @(negedge clk) begin
        logic [RND_W-1:0] e;
        if (syn_rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (prev_valid && !prev_ready && rnd_valid) chk("hold", rnd_out, prev_out);
            if (rnd_valid && rnd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty actual=%0h required=no_word", rnd_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", rnd_out, e);
                end
            end
            prev_out   <= rnd_out;
            prev_valid <= rnd_valid;
            prev_ready <= rnd_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [LFSR_W-1:0] sv, input logic [LFSR_W-1:0] model_sv,
                             input bit rdy);
        bit acc;
        int n;
        seed       = sv;
        seed_valid = 1'b1;
        rnd_ready  = rdy;
        acc        = 1'b0;
        n          = 0;
        while (!acc && n < 20) begin
            acc = seed_ready;
            step();
            n++;
        end
        seed_valid = 1'b0;
        seed       = {$urandom(), $urandom(), 16'(($urandom()))};
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL seed_accept actual=timeout required=accepted");
        end
        model_seed(model_sv, 1200);
        for (int i = 0; i < int'(WARMUP); i++) begin
            chk("warm_valid", rnd_valid, 1'b0);
            chk("warm_seed_ready", seed_ready, 1'b0);
            chk("warm_busy", busy, 1'b1);
            step();
        end
        chk("valid_rise", rnd_valid, 1'b1);
        chk("run_busy", busy, 1'b0);
        chk("run_seed_ready", seed_ready, 1'b1);
    endtask

    task automatic run_cycles(input int n, input bit always_ready);
        for (int i = 0; i < n; i++) begin
            rnd_ready = always_ready ? 1'b1 : 1'($urandom_range(0, 1));
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2*LFSR_W-1:0] pkg_res;
        logic [95:0]         r;
        logic [LFSR_W-1:0]   rseed;

        repeat (3) @(posedge clk);
        #1;
        syn_rst = 1'b0;

        for (int i = 0; i < 50; i++) begin
            chk("idle_valid", rnd_valid, 1'b0);
            chk("idle_seed_ready", seed_ready, 1'b1);
            chk("idle_out", rnd_out, '0);
            chk("idle_busy", busy, 1'b0);
            step();
        end

        // Package helper against the independent bit-stream model.
        model_load(80'h8000_0000_0000_0000_0000);
        pkg_res = lfsr_word(80'h8000_0000_0000_0000_0000, RND_W);
        chk("pkg_word", pkg_res[RND_W-1:0], model_word());

        load_seed(80'h8000_0000_0000_0000_0000, 80'h8000_0000_0000_0000_0000, 1'b1);
        chk("first_bit0", rnd_out[0], 1'b1);
        run_cycles(1000, 1'b1);

        // Zero seed maps onto 80'h1; reseed in RUN with rnd_ready high.
        load_seed(80'h0, 80'h1, 1'b1);
        run_cycles(200, 1'b1);
        load_seed(80'h1, 80'h1, 1'b1);
        run_cycles(200, 1'b1);

        r = {$urandom(), $urandom(), $urandom()};
        rseed = r[LFSR_W-1:0] | 80'h1;
        load_seed(rseed, rseed, 1'b1);
        run_cycles(600, 1'b0);

        r = {$urandom(), $urandom(), $urandom()};
        rseed = r[LFSR_W-1:0] | 80'h2;
        load_seed(rseed, rseed, 1'b0);
        run_cycles(300, 1'b0);

`ifdef GHPCLL_RND_RESEED_REQ_EN
        load_seed(rseed ^ 80'h5a5a, rseed ^ 80'h5a5a, 1'b0);
        chk("req_after_seed", reseed_req, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            rnd_ready = 1'b1;
            step();
            chk("reseed_req", reseed_req, 1'(i >= 4));
        end
        rnd_ready = 1'b0;
        load_seed(rseed, rseed, 1'b0);
        chk("req_cleared", reseed_req, 1'b0);
`endif

        // Reset in the middle of warm-up.
        rnd_ready = 1'b1;
        chk("pre_rst_seed_ready", seed_ready, 1'b1);
        seed       = rseed ^ 80'hf00f;
        seed_valid = 1'b1;
        step();
        seed_valid = 1'b0;
        chk("pre_rst_busy", busy, 1'b1);
        repeat (3) step();
        syn_rst = 1'b1;
        exp_q.delete();
        step();
        syn_rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", rnd_valid, 1'b0);
        chk("rst_seed_ready", seed_ready, 1'b1);
        chk("rst_out", rnd_out, '0);
        for (int i = 0; i < 20; i++) begin
            chk("post_rst_valid", rnd_valid, 1'b0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
